cart_ram_bridge: RTL
====================

Name: cart_ram_bridge

Overview:
- Sequences cartridge RAM accesses for the CPU. Sits directly downstream of the cartridge address decoder.
- Consumes the decoder's r_en, w_en and rebased address. Drives a wait-stated external or block cartridge RAM.
- Stalls the CPU through cpu_rdy until each access completes, and returns registered read data.

Parameters:
- ADDR_W, 15, RAM address width; addr_in[ADDR_W-1:0] is used, upper bits are ignored.
- DATA_W, 8, data bus width.
- READ_WAIT, 2, cycles ram_oe is held before read data is sampled; legal range 1..15.
- WRITE_WAIT, 1, cycles ram_we is held; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- r_en  in  1  read request from the address decoder.
- w_en  in  1  write request from the address decoder.
- addr_in  in  16  rebased cartridge address from the decoder.
- cpu_data_in  in  DATA_W  CPU write data.
- cpu_data_out  out  DATA_W  registered read data to the CPU.
- cpu_rdy  out  1  1 = CPU may advance; 0 = stall.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_data_out  out  DATA_W  registered RAM write data.
- ram_data_in  in  DATA_W  RAM read data.
- ram_ce  out  1  RAM chip enable.
- ram_oe  out  1  RAM output enable.
- ram_we  out  1  RAM write enable.
- busy  out  1  high in READ, WRITE or DONE.

Behaviour:
- Reset values: state IDLE; cpu_data_out, ram_addr, ram_data_out, wait counter = 0; ram_ce, ram_oe, ram_we = 0.
- Reset mid-access aborts the access; strobes drop on the same edge and no DONE pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - w_en=1 → latch ram_addr=addr_in[ADDR_W-1:0] and ram_data_out=cpu_data_in; set ram_ce=ram_we=1; counter=WRITE_WAIT-1; go WRITE.
  - Otherwise r_en=1 → latch ram_addr; set ram_ce=ram_oe=1; counter=READ_WAIT-1; go READ.
  - Simultaneous r_en and w_en is treated as a write (write priority).
- READ: when counter=0, capture cpu_data_out<=ram_data_in, clear ram_ce/ram_oe, go DONE. Otherwise decrement the counter.
- WRITE: when counter=0, clear ram_ce/ram_we, go DONE. Otherwise decrement the counter.
- DONE: exactly one cycle, then IDLE. Requests are not sampled in DONE; a request present in the following IDLE cycle starts a new access. Back-to-back accesses to the same address are therefore each serviced once.
- cpu_rdy (combinational) = (state==IDLE && !r_en && !w_en) || state==DONE.
  - The stall begins in the same cycle a request appears.
  - cpu_rdy must never be high in IDLE while a request is present.
- Latency, request seen in IDLE at edge 0:
  - Read: strobes asserted for READ_WAIT cycles; data captured at edge READ_WAIT; cpu_rdy=1 during cycle READ_WAIT; stall is READ_WAIT+1 cycles.
  - Write: same timing with WRITE_WAIT.
- Inputs in READ/WRITE: addr_in, cpu_data_in, r_en and w_en are ignored; the latched values hold.
- ram_oe and ram_we are never high together. ram_addr and ram_data_out hold their values after an access.
- cpu_data_out holds the last read value until the next read completes; writes do not change it.
- No requests → stays IDLE, cpu_rdy=1, all strobes 0.

Test Plan:
- Reset then idle, 10 cycles, no requests → cpu_rdy=1 every cycle; ram_ce/oe/we=0; cpu_data_out=0x00.
- READ_WAIT=2, r_en=1, addr_in=0x0123, ram_data_in=0x5A:
  - ram_addr=0x0123, ram_ce=ram_oe=1 for 2 cycles.
  - cpu_rdy=0 for cycles 0-1 and 1 at cycle 2.
  - cpu_data_out=0x5A from cycle 2.
- WRITE_WAIT=1, w_en=1, addr_in=0x7FFF, cpu_data_in=0xC3 → ram_addr=0x7FFF, ram_data_out=0xC3, ram_we=1 for 1 cycle, cpu_rdy pulse at cycle 1, cpu_data_out unchanged.
- r_en=w_en=1 with addr_in=0x0010, cpu_data_in=0x99 → write performed at 0x0010; ram_oe stays 0.
- Two consecutive reads of 0x0040 with r_en held high → two distinct ram_oe bursts separated by DONE then IDLE; two cpu_rdy pulses.
- reset asserted in the second READ cycle → next edge: state IDLE, strobes 0, cpu_data_out=0, no cpu_rdy pulse from the aborted access.

Source files
------------

// File: rtl/cart_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cart_ram_bridge
// Purpose  : Sequences wait-stated cartridge RAM reads and writes.
//            Stalls the CPU via cpu_rdy until each access completes.
// Revision : 1.0  initial release
// ============================================================================
module cart_ram_bridge #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r_en,
   input  logic              w_en,
   input  logic [15:0]       addr_in,
   input  logic [DATA_W-1:0] cpu_data_in,
   output logic [DATA_W-1:0] cpu_data_out,
   output logic              cpu_rdy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_out,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              ram_ce,
   output logic              ram_oe,
   output logic              ram_we,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] C_RD_INIT = 4'(READ_WAIT - 1);
   localparam logic [3:0] C_WR_INIT = 4'(WRITE_WAIT - 1);

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0]   r_dout, w_dout_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic                r_ce, w_ce_nxt;
   logic                r_oe, w_oe_nxt;
   logic                r_we, w_we_nxt;

   // Only the low ADDR_W address bits reach the RAM.
   if (ADDR_W < 16) begin : g_addr_unused
      logic w_unused_addr;
      assign w_unused_addr = ^addr_in[15:ADDR_W];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_ce_nxt    = r_ce;
      w_oe_nxt    = r_oe;
      w_we_nxt    = r_we;
      case (r_state)
         S_IDLE: begin
            if (w_en) begin
               w_addr_nxt  = addr_in[ADDR_W-1:0];
               w_wdata_nxt = cpu_data_in;
               w_ce_nxt    = 1'b1;
               w_we_nxt    = 1'b1;
               w_cnt_nxt   = C_WR_INIT;
               w_state_nxt = S_WRITE;
            end else if (r_en) begin
               w_addr_nxt  = addr_in[ADDR_W-1:0];
               w_ce_nxt    = 1'b1;
               w_oe_nxt    = 1'b1;
               w_cnt_nxt   = C_RD_INIT;
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (r_cnt == 4'd0) begin
               w_dout_nxt  = ram_data_in;
               w_ce_nxt    = 1'b0;
               w_oe_nxt    = 1'b0;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_WRITE: begin
            if (r_cnt == 4'd0) begin
               w_ce_nxt    = 1'b0;
               w_we_nxt    = 1'b0;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ce    <= 1'b0;
         r_oe    <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dout  <= w_dout_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_ce    <= w_ce_nxt;
         r_oe    <= w_oe_nxt;
         r_we    <= w_we_nxt;
      end
   end

   // The stall must start in the very cycle a request shows up in IDLE.
   assign cpu_rdy      = ((r_state == S_IDLE) && !r_en && !w_en) || (r_state == S_DONE);
   assign busy         = (r_state != S_IDLE);
   assign cpu_data_out = r_dout;
   assign ram_addr     = r_addr;
   assign ram_data_out = r_wdata;
   assign ram_ce       = r_ce;
   assign ram_oe       = r_oe;
   assign ram_we       = r_we;

endmodule
`default_nettype wire
